// File: rtl/hex_scan_if.sv
// Shadow-write / commit / display-drive signal bundle for hex_scan_ctrl.
// The master side is the timekeeping logic; the slave side is the scan controller.
interface hex_scan_if #(
  parameter int NUM_DIGITS = 6
);
  logic                  wr_en;
  logic [2:0]            wr_idx;
  logic [3:0]            wr_digit;
  logic                  wr_ready;
  logic                  commit;
  logic                  commit_done;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [3:0]            dec_digit;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic [2:0]            scan_idx;
  logic                  frame_tick;

  modport master (
    output wr_en, wr_idx, wr_digit, commit, blank_mask,
    input  wr_ready, commit_done, dec_digit, dig_sel, scan_idx, frame_tick
  );

  modport slave (
    input  wr_en, wr_idx, wr_digit, commit, blank_mask,
    output wr_ready, commit_done, dec_digit, dig_sel, scan_idx, frame_tick
  );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a shadow digit bank that is
// published to the display bank only at frame boundaries.
//
// state   | meaning
// S_BLANK | all digits off for BLANK cycles (anti-ghosting guard)
// S_ON    | digit scan_idx lit for DWELL cycles
module hex_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int DWELL      = 50000,
  parameter int BLANK      = 500
) (
  input  logic      clk,
  input  logic      rst_n,
  hex_scan_if.slave bus
);

  localparam int MAXC = (BLANK > DWELL) ? BLANK : DWELL;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            scan_q, scan_d;
  logic [3:0]            shadow_q  [NUM_DIGITS];
  logic [3:0]            shadow_d  [NUM_DIGITS];
  logic [3:0]            display_q [NUM_DIGITS];
  logic [3:0]            display_d [NUM_DIGITS];
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [3:0]            dec_q, dec_d;
  logic                  done_q, done_d;
  logic                  tick_q, tick_d;
  logic                  boundary;
  logic                  wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BLANK;
      cnt_q     <= '0;
      scan_q    <= '0;
      pending_q <= 1'b0;
      dig_sel_q <= '1;
      dec_q     <= 4'hF;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i]  <= 4'hF;
        display_q[i] <= 4'hF;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scan_q    <= scan_d;
      pending_q <= pending_d;
      dig_sel_q <= dig_sel_d;
      dec_q     <= dec_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
    end
  end

  assign boundary = (state_q == S_ON) && (cnt_q == DWELL_LAST) && (scan_q == LAST_IDX);
  assign wr_ok    = bus.wr_en && !pending_q && ({1'b0, bus.wr_idx} < 4'(NUM_DIGITS));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    scan_d    = scan_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          scan_d  = (scan_q == LAST_IDX) ? 3'd0 : scan_q + 3'd1;
        end
      end
      default: state_d = S_BLANK;
    endcase
    if (wr_ok)
      shadow_d[bus.wr_idx] = bus.wr_digit;
    // A commit arriving on the boundary edge itself only becomes pending.
    if (boundary && pending_q) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end else if (bus.commit && !pending_q) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    tick_d    = boundary;
    done_d    = boundary && pending_q;
    dig_sel_d = '1;
    dec_d     = 4'hF;
    if (state_d == S_ON) begin
      dig_sel_d[scan_d] = 1'b0;
      if (!bus.blank_mask[scan_d])
        dec_d = display_q[scan_d];
    end
  end

  assign bus.wr_ready    = ~pending_q;
  assign bus.commit_done = done_q;
  assign bus.frame_tick  = tick_q;
  assign bus.dig_sel     = dig_sel_q;
  assign bus.dec_digit   = dec_q;
  assign bus.scan_idx    = scan_q;

endmodule
